sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Sequences the shared external 256K×16 asynchronous SRAM (18-bit address, 16-bit bidirectional data, 5-bit active-low control bus) and shares it between two requesters.
- Master 0 is the CPU data port. Master 1 is the I/O sampler that logs switch/button snapshots.
- The block applies the SRAM's multi-cycle timing and round-robin fairness, so neither requester drives the pins directly.

Parameters:
- AW, 18, SRAM address width
- DW, 16, SRAM data width
- WAIT_CYCLES, 1, extra ACCESS cycles per transfer (0..7)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset
- m0_req  input  1  master 0 request; held high until m0_ack
- m0_we  input  1  master 0 direction: 1 = write, 0 = read
- m0_addr  input  AW  master 0 word address
- m0_wdata  input  DW  master 0 write data
- m0_be  input  2  master 0 byte enables, {upper, lower}, active-high
- m0_ack  output  1  one-cycle completion pulse to master 0
- m0_rdata  output  DW  master 0 read data; valid from the m0_ack cycle until the next master 0 read completes
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_ack, m1_rdata: identical to master 0, for master 1
- sram_addr  output  AW  SRAM address pins
- sram_ctrl  output  5  SRAM control, {ce_n, oe_n, we_n, ub_n, lb_n}, all active-low
- sram_data  inout  DW  SRAM data pins; driven only during write SETUP/ACCESS/DONE, high-Z otherwise
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (reset = 0, asynchronous, effective immediately, including mid-transfer):
  - state = IDLE; sram_ctrl = 5'b11111; sram_addr = 0; sram_data = high-Z.
  - m0_ack = m1_ack = 0; m0_rdata = m1_rdata = 0; busy = 0.
  - last_grant = 1, so master 0 wins the first tie.
  - An aborted transfer produces no ack. The requester retries by keeping req high after reset releases.
- FSM states and transitions:
  - IDLE -> SETUP when any req is high at the edge. That edge latches grant, we, addr, wdata and be into internal registers. Master inputs are ignored after latching.
  - SETUP (1 cycle): sram_addr valid; ce_n = 0; ub_n/lb_n = ~be. On a read, oe_n = 0. On a write, oe_n = 1, we_n = 1, and data is driven.
  - ACCESS (WAIT_CYCLES+1 cycles, counted by a 3-bit down-counter): signals as in SETUP, except that on a write we_n = 0. On a read, sram_data is sampled into the granted master's rdata register at the last ACCESS edge.
  - DONE (1 cycle): we_n = 1 and oe_n = 1. ce_n and address are held; write data is held (hold time). The granted master's ack is high. Then -> IDLE.
- Latency: with req sampled at edge E0, ack is high during the cycle following edge E(WAIT_CYCLES+2). Default: ack is seen 4 cycles after the req-sampling edge. The minimum request-to-request period is WAIT_CYCLES+4 cycles.
- Arbitration (evaluated only in IDLE):
  - Only one req high: that master is granted.
  - Both high: the master that is not last_grant is granted. last_grant updates on every grant.
  - No starvation: with both requesting continuously, grants alternate strictly.
- Handshake rules:
  - The master deasserts req in the cycle after seeing ack. If req is still high when the FSM is back in IDLE, it is treated as a new request (back-to-back allowed).
  - A request from the non-granted master raised mid-transfer waits; it is served in the next IDLE.
  - be = 2'b00 performs a full bus cycle with ub_n = lb_n = 1, and ack is still returned.
- Address and data widths pass through unmodified. There is no address wrap or increment inside the block.

Decomposition:
- Package sram_pkg:
  - state encoding (IDLE, SETUP, ACCESS, DONE)
  - sram_ctrl bit indices CE, OE, WE, UB, LB
  - constant SRAM_CTRL_IDLE = 5'b11111
  - master index constants M_CPU = 0, M_IO = 1
- Sub-module rr_arbiter2: two-input round-robin arbiter with a last_grant register. Inputs: req[1:0] and an enable strobe. Outputs: one-hot grant.

Test Plan:
- Single read:
  - Stimulus: SRAM model holds 16'hBEEF at 18'h00010; m0 reads with be = 2'b11.
  - Required response: m0_ack 4 cycles after the sampling edge; m0_rdata = 16'hBEEF; oe_n low only in SETUP/ACCESS; we_n stays high throughout.
- Write then read-back:
  - Stimulus: m1 writes 16'h5555 to 18'h3FFFF with be = 2'b01, then reads the same address.
  - Required response: the model shows only the low byte updated to 8'h55; we_n is low only in the ACCESS cycle; data is high-Z by the cycle after DONE.
- Contention:
  - Stimulus: m0_req and m1_req both held high from reset release, for 6 transfers.
  - Required response: grants go m0, m1, m0, m1, m0, m1; each ack is a single cycle; the two acks are never high together.
- Wait states:
  - Stimulus: WAIT_CYCLES = 3, one read.
  - Required response: ACCESS lasts 4 cycles; ack is seen 6 cycles after the sampling edge.
- Reset mid-transfer:
  - Stimulus: assert reset during a write ACCESS cycle.
  - Required response, same cycle (asynchronous): sram_ctrl = 5'b11111, data bus high-Z, no ack.
  - After release with req still high: the transfer restarts from SETUP, and master 0 wins a tie.
- Back-to-back:
  - Stimulus: m0 keeps req high across its ack.
  - Required response: a second transfer starts from IDLE on the next edge; busy drops for exactly one cycle between the transfers.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants for the external SRAM sequencer: FSM encoding, control-bus
// bit positions, idle control word, master indices and a control-word builder.
package sram_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // Bit positions inside sram_ctrl = {ce_n, oe_n, we_n, ub_n, lb_n}
   localparam int CE = 4;
   localparam int OE = 3;
   localparam int WE = 2;
   localparam int UB = 1;
   localparam int LB = 0;

   // All strobes deasserted
   localparam logic [4:0] SRAM_CTRL_IDLE = 5'b11111;

   // Master indices, also the encoding of the latched grant
   localparam logic M_CPU = 1'b0;
   localparam logic M_IO  = 1'b1;

   // Assemble an active-low control word; byte lanes follow the active-high enables
   function automatic logic [4:0] ctrl_word(input logic       ce_n,
                                            input logic       oe_n,
                                            input logic       we_n,
                                            input logic [1:0] be);
      logic [4:0] w;
      w     = SRAM_CTRL_IDLE;
      w[CE] = ce_n;
      w[OE] = oe_n;
      w[WE] = we_n;
      w[UB] = ~be[1];
      w[LB] = ~be[0];
      return w;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. On a tie the master that did not win last
// time is granted; last_grant remembers the most recent winner.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] grant
);

   logic last_grant;

   // One-hot grant: a lone requester wins, a tie goes to the one not served last
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves grant unassigned (that would infer a latch).
      grant = 2'b00;
      if (en) begin
         if (req[0] && (!req[1] || last_grant))
            grant = 2'b01;
         else if (req[1])
            grant = 2'b10;
      end
   end

   // Remember the winner of every grant; master 0 wins the first tie after reset
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!reset)
         last_grant <= 1'b1;
      else if (|grant)
         last_grant <= grant[1];
   end

endmodule

// File: rtl/sram_arbiter.sv
// Sequencer for the shared asynchronous 256Kx16 SRAM. Two masters (CPU data
// port and I/O sampler) are arbitrated round-robin; each granted transfer runs
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE -> IDLE.
module sram_arbiter
   import sram_pkg::*;
#(
   parameter int AW          = 18,
   parameter int DW          = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic [1:0]    m0_be,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic [1:0]    m1_be,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] sram_addr,
   output logic [4:0]    sram_ctrl,
   inout  wire  [DW-1:0] sram_data,
   output logic          busy
);

   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

   logic [1:0]    state_q;
   logic [2:0]    cnt_q;
   logic [1:0]    grant;
   logic          gnt_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [1:0]    be_q;
   logic          data_oe;

   rr_arbiter2 u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({m1_req, m0_req}),
      .en    (state_q == ST_IDLE),
      .grant (grant)
   );

   // Transfer sequencing; ACCESS length is set by the wait-state down-counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         case (state_q)
            ST_IDLE:   if (|grant) state_q <= ST_SETUP;
            ST_SETUP: begin
               state_q <= ST_ACCESS;
               cnt_q   <= WAIT_LOAD;
            end
            ST_ACCESS: begin
               if (cnt_q == 3'd0)
                  state_q <= ST_DONE;
               else
                  cnt_q <= cnt_q - 3'd1;
            end
            default:   state_q <= ST_IDLE;
         endcase
      end
   end

   // Capture the winner's command at the grant edge; later master changes are ignored
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gnt_q   <= M_CPU;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= 2'b00;
      end else if (|grant) begin
         gnt_q   <= grant[1];
         we_q    <= grant[1] ? m1_we    : m0_we;
         addr_q  <= grant[1] ? m1_addr  : m0_addr;
         wdata_q <= grant[1] ? m1_wdata : m0_wdata;
         be_q    <= grant[1] ? m1_be    : m0_be;
      end
   end

   // Sample the data pins into the granted master's read register on the last ACCESS edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else if (state_q == ST_ACCESS && cnt_q == 3'd0 && !we_q) begin
         if (gnt_q == M_IO)
            m1_rdata <= sram_data;
         else
            m0_rdata <= sram_data;
      end
   end

   // Control strobes per state: write strobe only in ACCESS, output enable off in DONE
   always_comb begin
      sram_ctrl = SRAM_CTRL_IDLE;
      case (state_q)
         ST_SETUP:  sram_ctrl = ctrl_word(1'b0, we_q, 1'b1,  be_q);
         ST_ACCESS: sram_ctrl = ctrl_word(1'b0, we_q, ~we_q, be_q);
         ST_DONE:   sram_ctrl = ctrl_word(1'b0, 1'b1, 1'b1,  be_q);
         default:   sram_ctrl = SRAM_CTRL_IDLE;
      endcase
   end

   // Write data is driven from SETUP through DONE so it is stable around the we_n pulse
   assign data_oe   = we_q && (state_q != ST_IDLE);
   assign sram_data = data_oe ? wdata_q : {DW{1'bz}};
   assign sram_addr = addr_q;
   assign busy      = (state_q != ST_IDLE);
   assign m0_ack    = (state_q == ST_DONE) && (gnt_q == M_CPU);
   assign m1_ack    = (state_q == ST_DONE) && (gnt_q == M_IO);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a default-timing instance on an SRAM model
// and a WAIT_CYCLES=3 instance on a fixed read pattern.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        reset;

   logic        m0_req, m0_we, m1_req, m1_we;
   logic [17:0] m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;
   logic [1:0]  m0_be, m1_be;
   logic        m0_ack, m1_ack, busy;
   logic [15:0] m0_rdata, m1_rdata;
   logic [17:0] sram_addr;
   logic [4:0]  sram_ctrl;
   wire  [15:0] sram_data;

   logic        w_m0_req, w_m0_we, w_m1_req, w_m1_we;
   logic [17:0] w_m0_addr, w_m1_addr;
   logic [15:0] w_m0_wdata, w_m1_wdata;
   logic [1:0]  w_m0_be, w_m1_be;
   logic        w_m0_ack, w_m1_ack, w_busy;
   logic [15:0] w_m0_rdata, w_m1_rdata;
   logic [17:0] w_sram_addr;
   logic [4:0]  w_sram_ctrl;
   wire  [15:0] w_sram_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_arbiter dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_be(m0_be), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_be(m1_be), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
      .sram_addr(sram_addr), .sram_ctrl(sram_ctrl), .sram_data(sram_data),
      .busy(busy)
   );

   sram_arbiter #(.WAIT_CYCLES(3)) dut_w3 (
      .clk(clk), .reset(reset),
      .m0_req(w_m0_req), .m0_we(w_m0_we), .m0_addr(w_m0_addr), .m0_wdata(w_m0_wdata),
      .m0_be(w_m0_be), .m0_ack(w_m0_ack), .m0_rdata(w_m0_rdata),
      .m1_req(w_m1_req), .m1_we(w_m1_we), .m1_addr(w_m1_addr), .m1_wdata(w_m1_wdata),
      .m1_be(w_m1_be), .m1_ack(w_m1_ack), .m1_rdata(w_m1_rdata),
      .sram_addr(w_sram_addr), .sram_ctrl(w_sram_ctrl), .sram_data(w_sram_data),
      .busy(w_busy)
   );

   // Asynchronous SRAM model: reads drive while ce_n/oe_n low and we_n high,
   // writes commit on the rising edge of we_n with ce_n low.
   logic [15:0] mem [0:262143];
   wire ce_n = sram_ctrl[4];
   wire oe_n = sram_ctrl[3];
   wire we_n = sram_ctrl[2];
   wire ub_n = sram_ctrl[1];
   wire lb_n = sram_ctrl[0];

   assign sram_data   = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;
   assign w_sram_data = (!w_sram_ctrl[4] && !w_sram_ctrl[3]) ? 16'h7E57 : 16'hzzzz;

   initial begin
      mem[18'h00010] = 16'hBEEF;
      mem[18'h00020] = 16'h0000;
      mem[18'h3FFFF] = 16'hA1B2;
      forever begin
         @(posedge we_n);
         if (ce_n === 1'b0) begin
            if (!ub_n) mem[sram_addr][15:8] = sram_data[15:8];
            if (!lb_n) mem[sram_addr][7:0]  = sram_data[7:0];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = 2'b00;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = 2'b00;
      w_m0_req = 0; w_m0_we = 0; w_m0_addr = '0; w_m0_wdata = '0; w_m0_be = 2'b00;
      w_m1_req = 0; w_m1_we = 0; w_m1_addr = '0; w_m1_wdata = '0; w_m1_be = 2'b00;
      tick();
      tick();

      // reset state
      check("rst_ctrl", sram_ctrl, 5'b11111);
      check("rst_addr", sram_addr, 18'h0);
      check("rst_oe", dut.data_oe, 1'b0);
      check("rst_ack", {m0_ack, m1_ack}, 2'b00);
      check("rst_rdata", {m0_rdata, m1_rdata}, 32'h0);
      check("rst_busy", busy, 1'b0);
      reset = 1'b1;

      // single read by m0
      m0_we = 0; m0_addr = 18'h00010; m0_be = 2'b11; m0_req = 1;
      tick();
      check("rd_setup_busy", busy, 1'b1);
      check("rd_setup_ctrl", sram_ctrl, 5'b00100);
      check("rd_setup_addr", sram_addr, 18'h00010);
      tick();
      check("rd_acc1_ctrl", sram_ctrl, 5'b00100);
      check("rd_acc1_ack", m0_ack, 1'b0);
      tick();
      check("rd_acc2_ctrl", sram_ctrl, 5'b00100);
      check("rd_acc2_ack", m0_ack, 1'b0);
      tick();
      check("rd_done_ack", {m0_ack, m1_ack}, 2'b10);
      check("rd_done_ctrl", sram_ctrl, 5'b01100);
      check("rd_done_rdata", m0_rdata, 16'hBEEF);
      m0_req = 0;
      tick();
      check("rd_idle_busy", busy, 1'b0);
      check("rd_idle_ack", m0_ack, 1'b0);
      check("rd_idle_ctrl", sram_ctrl, 5'b11111);
      check("rd_idle_rdata", m0_rdata, 16'hBEEF);

      // m1 low-byte write to the top address
      m1_we = 1; m1_addr = 18'h3FFFF; m1_wdata = 16'h5555; m1_be = 2'b01; m1_req = 1;
      tick();
      check("wr_setup_ctrl", sram_ctrl, 5'b01110);
      check("wr_setup_oe", dut.data_oe, 1'b1);
      check("wr_setup_data", sram_data, 16'h5555);
      check("wr_setup_addr", sram_addr, 18'h3FFFF);
      tick();
      check("wr_acc1_ctrl", sram_ctrl, 5'b01010);
      tick();
      check("wr_acc2_ctrl", sram_ctrl, 5'b01010);
      tick();
      check("wr_done_ack", {m0_ack, m1_ack}, 2'b01);
      check("wr_done_ctrl", sram_ctrl, 5'b01110);
      check("wr_done_oe", dut.data_oe, 1'b1);
      check("wr_mem", mem[18'h3FFFF], 16'hA155);
      m1_req = 0;
      tick();
      check("wr_idle_oe", dut.data_oe, 1'b0);
      check("wr_idle_ctrl", sram_ctrl, 5'b11111);

      // m1 reads it back
      m1_we = 0; m1_be = 2'b11; m1_req = 1;
      tick();
      tick();
      tick();
      tick();
      check("rb_done_ack", m1_ack, 1'b1);
      check("rb_rdata", m1_rdata, 16'hA155);
      check("rb_m0_rdata_kept", m0_rdata, 16'hBEEF);
      m1_req = 0;
      tick();

      // be = 00: full cycle, no lanes, still acked
      m0_we = 1; m0_addr = 18'h00010; m0_wdata = 16'h1234; m0_be = 2'b00; m0_req = 1;
      tick();
      check("be0_setup_ctrl", sram_ctrl, 5'b01111);
      tick();
      check("be0_acc_ctrl", sram_ctrl, 5'b01011);
      tick();
      tick();
      check("be0_done_ack", m0_ack, 1'b1);
      m0_req = 0;
      tick();
      check("be0_mem", mem[18'h00010], 16'hBEEF);

      // back-to-back: m0 holds req across ack
      m0_we = 0; m0_addr = 18'h3FFFF; m0_be = 2'b11; m0_req = 1;
      tick();
      tick();
      tick();
      tick();
      check("b2b_ack1", m0_ack, 1'b1);
      check("b2b_rdata", m0_rdata, 16'hA155);
      tick();
      check("b2b_gap_busy", busy, 1'b0);
      check("b2b_gap_ack", m0_ack, 1'b0);
      tick();
      check("b2b_restart_busy", busy, 1'b1);
      tick();
      tick();
      tick();
      check("b2b_ack2", m0_ack, 1'b1);
      m0_req = 0;
      tick();
      check("b2b_end_busy", busy, 1'b0);

      // contention from reset release: strict alternation m0, m1, ...
      reset = 1'b0;
      m0_we = 0; m0_addr = 18'h00010; m0_be = 2'b11; m0_req = 1;
      m1_we = 0; m1_addr = 18'h3FFFF; m1_be = 2'b11; m1_req = 1;
      tick();
      reset = 1'b1;
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < 3; c++) begin
            tick();
            check("ct_no_ack", {m0_ack, m1_ack}, 2'b00);
         end
         tick();
         check("ct_grant", {m0_ack, m1_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
         if (k % 2 == 0)
            check("ct_m0_rdata", m0_rdata, 16'hBEEF);
         else
            check("ct_m1_rdata", m1_rdata, 16'hA155);
         if (k == 5) begin
            m0_req = 0;
            m1_req = 0;
         end
         tick();
         check("ct_single_ack", {m0_ack, m1_ack}, 2'b00);
      end

      // reset in the middle of a write ACCESS
      reset = 1'b0;
      m0_we = 1; m0_addr = 18'h00020; m0_wdata = 16'hCAFE; m0_be = 2'b11; m0_req = 1;
      m1_we = 0; m1_addr = 18'h00010; m1_be = 2'b11; m1_req = 1;
      tick();
      reset = 1'b1;
      tick();
      check("ab_setup_addr", sram_addr, 18'h00020);
      tick();
      check("ab_acc_ctrl", sram_ctrl, 5'b01000);
      #2;
      reset = 1'b0;
      #1;
      check("ab_async_ctrl", sram_ctrl, 5'b11111);
      check("ab_async_oe", dut.data_oe, 1'b0);
      check("ab_async_ack", {m0_ack, m1_ack}, 2'b00);
      check("ab_async_busy", busy, 1'b0);
      check("ab_async_rdata", {m0_rdata, m1_rdata}, 32'h0);
      tick();
      check("ab_no_write", mem[18'h00020], 16'h0000);
      check("ab_held_ack", {m0_ack, m1_ack}, 2'b00);
      reset = 1'b1;
      tick();
      check("ab_retry_addr", sram_addr, 18'h00020);
      check("ab_retry_ctrl", sram_ctrl, 5'b01100);
      check("ab_retry_oe", dut.data_oe, 1'b1);
      tick();
      tick();
      tick();
      check("ab_retry_ack", {m0_ack, m1_ack}, 2'b10);
      check("ab_retry_mem", mem[18'h00020], 16'hCAFE);
      m0_req = 0;
      tick();
      tick();
      check("ab_m1_addr", sram_addr, 18'h00010);
      tick();
      tick();
      tick();
      check("ab_m1_ack", {m0_ack, m1_ack}, 2'b01);
      check("ab_m1_rdata", m1_rdata, 16'hBEEF);
      m1_req = 0;
      tick();

      // WAIT_CYCLES = 3: four ACCESS cycles, ack six cycles after sampling
      w_m0_we = 0; w_m0_addr = 18'h00055; w_m0_be = 2'b11; w_m0_req = 1;
      tick();
      check("ws_setup_busy", w_busy, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("ws_acc_ctrl", w_sram_ctrl, 5'b00100);
         check("ws_acc_ack", w_m0_ack, 1'b0);
      end
      tick();
      check("ws_done_ack", w_m0_ack, 1'b1);
      check("ws_rdata", w_m0_rdata, 16'h7E57);
      w_m0_req = 0;
      tick();
      check("ws_idle_busy", w_busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
